// File: rtl/window_sum_sched_if.sv
// Bus between the window-sum sequencer, its line-sum source, the combinational
// window adder and the downstream threshold stage.
interface window_sum_sched_if #(
    parameter int DATA_W  = 32,
    parameter int N_LINES = 8
);
    // Both streams are valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; the producer holds data stable until then.
    logic                        frame_start;
    logic                        in_valid;
    logic                        in_ready;
    logic [DATA_W-1:0]           in_linesum;
    logic [N_LINES*DATA_W-1:0]   win_data;
    logic [DATA_W-1:0]           win_sum;
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_W-1:0]           out_sum;
    logic [15:0]                 out_index;

    modport slave (
        input  frame_start, in_valid, in_linesum, win_sum, out_ready,
        output in_ready, win_data, out_valid, out_sum, out_index
    );

    modport master (
        output frame_start, in_valid, in_linesum, win_sum, out_ready,
        input  in_ready, win_data, out_valid, out_sum, out_index
    );
endinterface

// File: rtl/window_sum_sched.sv
// Keeps the last N_LINES signed line sums, feeds them to an external adder and
// emits one registered window sum per new row once the window is full.
module window_sum_sched #(
    parameter int DATA_W  = 32,
    parameter int N_LINES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    window_sum_sched_if.slave     bus,
    output logic [1:0]            dbg_state_o
);
    localparam int CNT_W = $clog2(N_LINES + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(N_LINES);

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        CAPTURE = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t                             state_q, state_d;
    logic [N_LINES-1:0][DATA_W-1:0]     slots_q, slots_d;
    logic [CNT_W-1:0]                   fill_cnt_q, fill_cnt_d;
    logic [DATA_W-1:0]                  out_sum_q, out_sum_d;
    logic [15:0]                        out_index_q, out_index_d;
    logic                               accept;

    assign accept        = bus.in_valid && (state_q == FILL);
    assign bus.in_ready  = (state_q == FILL);
    assign bus.out_valid = (state_q == OUTPUT);
    assign bus.win_data  = slots_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_index = out_index_q;
    assign dbg_state_o   = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FILL;
            slots_q     <= '0;
            fill_cnt_q  <= '0;
            out_sum_q   <= '0;
            out_index_q <= '0;
        end else begin
            state_q     <= state_d;
            slots_q     <= slots_d;
            fill_cnt_q  <= fill_cnt_d;
            out_sum_q   <= out_sum_d;
            out_index_q <= out_index_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        slots_d     = slots_q;
        fill_cnt_d  = fill_cnt_q;
        out_sum_d   = out_sum_q;
        out_index_d = out_index_q;

        if (bus.frame_start) begin
            // A line accepted alongside frame_start opens the new frame.
            state_d     = FILL;
            slots_d     = '0;
            fill_cnt_d  = '0;
            out_index_d = '0;
            if (accept) begin
                slots_d[N_LINES-1] = bus.in_linesum;
                fill_cnt_d         = CNT_W'(1);
            end
        end else begin
            unique case (state_q)
                FILL: begin
                    if (accept) begin
                        slots_d = {bus.in_linesum, slots_q[N_LINES-1:1]};
                        if (fill_cnt_q != FULL) begin
                            fill_cnt_d = fill_cnt_q + CNT_W'(1);
                        end
                        if (fill_cnt_q >= FULL - CNT_W'(1)) begin
                            state_d = CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    out_sum_d = bus.win_sum;
                    state_d   = OUTPUT;
                end
                OUTPUT: begin
                    if (bus.out_ready) begin
                        out_index_d = out_index_q + 16'd1;
                        state_d     = FILL;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_window_sum_sched.sv
// Directed bench for window_sum_sched; the adder on win_data is modelled here.
module tb_window_sum_sched;
    localparam int DATA_W  = 32;
    localparam int N_LINES = 8;
    localparam logic [1:0] S_FILL    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_OUTPUT  = 2'd2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;
    int         errors = 0;
    int         checks = 0;

    window_sum_sched_if #(.DATA_W(DATA_W), .N_LINES(N_LINES)) bus ();

    window_sum_sched #(.DATA_W(DATA_W), .N_LINES(N_LINES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    // Combinational window adder, independent of the DUT internals.
    always_comb begin
        logic [DATA_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < N_LINES; i++) acc = acc + bus.win_data[DATA_W*i +: DATA_W];
        bus.win_sum = acc;
    end

    function automatic logic [DATA_W-1:0] slot(input int i);
        return bus.win_data[DATA_W*i +: DATA_W];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_line(input logic [DATA_W-1:0] v);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 20) begin
            step();
            guard++;
        end
        if (!bus.in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, guard);
        end
        bus.in_valid   = 1'b1;
        bus.in_linesum = v;
        step();
        bus.in_valid   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_linesum = 32'd123;
        repeat (3) step();
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        checks++; if (bus.win_data !== '0) begin errors++; $display("FAIL reset_win_data: got %h, required 0", bus.win_data); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready); end
        checks++; if (bus.out_index !== 16'd0) begin errors++; $display("FAIL reset_out_index: got %0d, required 0", bus.out_index); end
        checks++; if (bus.out_sum !== 32'd0) begin errors++; $display("FAIL reset_out_sum: got %0d, required 0", bus.out_sum); end
        checks++; if (dbg_state !== S_FILL) begin errors++; $display("FAIL reset_state: got %0d, required %0d", dbg_state, S_FILL); end
    endtask

    task automatic test_fill();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_line(32'd10);
        checks++; if (dbg_state !== S_CAPTURE) begin errors++; $display("FAIL fill_capture_state: got %0d, required %0d", dbg_state, S_CAPTURE); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_capture_in_ready: got %b, required 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fill_capture_out_valid: got %b, required 0", bus.out_valid); end
        step();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL fill_out_valid: got %b, required 1", bus.out_valid); end
        checks++; if (bus.out_sum !== 32'd80) begin errors++; $display("FAIL fill_out_sum: got %0d, required 80", $signed(bus.out_sum)); end
        checks++; if (bus.out_index !== 16'd0) begin errors++; $display("FAIL fill_out_index: got %0d, required 0", bus.out_index); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_output_in_ready: got %b, required 0", bus.in_ready); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fill_after_hs_out_valid: got %b, required 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL fill_after_hs_in_ready: got %b, required 1", bus.in_ready); end
        checks++; if (bus.out_index !== 16'd1) begin errors++; $display("FAIL fill_after_hs_index: got %0d, required 1", bus.out_index); end
    endtask

    task automatic test_slide();
        logic [DATA_W-1:0] exp_sum [2];
        logic [DATA_W-1:0] lines [2];
        exp_sum[0] = 32'd90;  lines[0] = 32'd20;
        exp_sum[1] = 32'd110; lines[1] = 32'd30;
        for (int k = 0; k < 2; k++) begin
            send_line(lines[k]);
            step();
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL slide_out_valid[%0d]: got %b, required 1", k, bus.out_valid); end
            checks++; if (bus.out_sum !== exp_sum[k]) begin errors++; $display("FAIL slide_out_sum[%0d]: got %0d, required %0d", k, $signed(bus.out_sum), exp_sum[k]); end
            checks++; if (bus.out_index !== 16'(k + 1)) begin errors++; $display("FAIL slide_out_index[%0d]: got %0d, required %0d", k, bus.out_index, k + 1); end
            step();
        end
        checks++; if (slot(7) !== 32'd30) begin errors++; $display("FAIL slide_slot7: got %0d, required 30", slot(7)); end
        checks++; if (slot(6) !== 32'd20) begin errors++; $display("FAIL slide_slot6: got %0d, required 20", slot(6)); end
        checks++; if (slot(0) !== 32'd10) begin errors++; $display("FAIL slide_slot0: got %0d, required 10", slot(0)); end
    endtask

    task automatic test_backpressure_signs();
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        checks++; if (bus.win_data !== '0) begin errors++; $display("FAIL bp_cleared_win_data: got %h, required 0", bus.win_data); end
        checks++; if (bus.out_index !== 16'd0) begin errors++; $display("FAIL bp_cleared_index: got %0d, required 0", bus.out_index); end
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_line(-32'sd5);
        step();
        bus.in_valid   = 1'b1;
        bus.in_linesum = 32'd999;
        for (int c = 0; c < 5; c++) begin
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b, required 1", c, bus.out_valid); end
            checks++; if (bus.out_sum !== -32'sd40) begin errors++; $display("FAIL bp_out_sum[%0d]: got %0d, required -40", c, $signed(bus.out_sum)); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b, required 0", c, bus.in_ready); end
            step();
        end
        checks++; if (slot(7) !== -32'sd5) begin errors++; $display("FAIL bp_slot7_unconsumed: got %0d, required -5", $signed(slot(7))); end
        checks++; if (slot(0) !== -32'sd5) begin errors++; $display("FAIL bp_slot0_unconsumed: got %0d, required -5", $signed(slot(0))); end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b, required 1", bus.in_ready); end
        checks++; if (bus.out_index !== 16'd1) begin errors++; $display("FAIL bp_release_index: got %0d, required 1", bus.out_index); end
    endtask

    task automatic test_frame_start();
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        for (int i = 0; i < 5; i++) send_line(32'd7);
        checks++; if (slot(3) !== 32'd7 || slot(2) !== 32'd0) begin errors++; $display("FAIL fs_partial_fill: got slot3=%0d slot2=%0d, required 7 and 0", slot(3), slot(2)); end
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        checks++; if (bus.win_data !== '0) begin errors++; $display("FAIL fs_mid_fill_clear: got %h, required 0", bus.win_data); end
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send_line(32'(i));
        checks++; if (dbg_state !== S_CAPTURE) begin errors++; $display("FAIL fs_capture_state: got %0d, required %0d", dbg_state, S_CAPTURE); end
        step();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL fs_out_valid: got %b, required 1", bus.out_valid); end
        checks++; if (bus.out_sum !== 32'd36) begin errors++; $display("FAIL fs_out_sum: got %0d, required 36", $signed(bus.out_sum)); end
        checks++; if (bus.out_index !== 16'd0) begin errors++; $display("FAIL fs_out_index: got %0d, required 0", bus.out_index); end
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fs_in_output_out_valid: got %b, required 0", bus.out_valid); end
        checks++; if (dbg_state !== S_FILL) begin errors++; $display("FAIL fs_in_output_state: got %0d, required %0d", dbg_state, S_FILL); end
        checks++; if (bus.win_data !== '0) begin errors++; $display("FAIL fs_in_output_win_data: got %h, required 0", bus.win_data); end
    endtask

    task automatic test_simultaneous();
        bus.out_ready   = 1'b1;
        bus.frame_start = 1'b1;
        bus.in_valid    = 1'b1;
        bus.in_linesum  = 32'd100;
        step();
        bus.frame_start = 1'b0;
        bus.in_valid    = 1'b0;
        checks++; if (slot(7) !== 32'd100 || slot(6) !== 32'd0) begin errors++; $display("FAIL sim_slots: got slot7=%0d slot6=%0d, required 100 and 0", slot(7), slot(6)); end
        checks++; if (dbg_state !== S_FILL) begin errors++; $display("FAIL sim_state: got %0d, required %0d", dbg_state, S_FILL); end
        for (int i = 0; i < 6; i++) send_line(32'd0);
        checks++; if (dbg_state !== S_FILL) begin errors++; $display("FAIL sim_not_full_after_7: got %0d, required %0d", dbg_state, S_FILL); end
        send_line(32'd0);
        checks++; if (dbg_state !== S_CAPTURE) begin errors++; $display("FAIL sim_full_after_8: got %0d, required %0d", dbg_state, S_CAPTURE); end
        step();
        checks++; if (bus.out_sum !== 32'd100) begin errors++; $display("FAIL sim_out_sum: got %0d, required 100", $signed(bus.out_sum)); end
        checks++; if (bus.out_index !== 16'd0) begin errors++; $display("FAIL sim_out_index: got %0d, required 0", bus.out_index); end
        step();
    endtask

    task automatic test_reset_mid();
        send_line(32'd3);
        send_line(32'd4);
        rst_n          = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_linesum = 32'd55;
        step();
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        checks++; if (bus.win_data !== '0) begin errors++; $display("FAIL rstmid_win_data: got %h, required 0", bus.win_data); end
        checks++; if (bus.out_sum !== 32'd0) begin errors++; $display("FAIL rstmid_out_sum: got %0d, required 0", $signed(bus.out_sum)); end
        checks++; if (bus.out_index !== 16'd0) begin errors++; $display("FAIL rstmid_out_index: got %0d, required 0", bus.out_index); end
        checks++; if (dbg_state !== S_FILL) begin errors++; $display("FAIL rstmid_state: got %0d, required %0d", dbg_state, S_FILL); end
    endtask

    initial begin
        bus.frame_start = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_linesum  = '0;
        bus.out_ready   = 1'b1;
        test_reset();
        test_fill();
        test_slide();
        test_backpressure_signs();
        test_frame_start();
        test_simultaneous();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
